// File: rtl/wb_pkg.sv
// Shared types for the Wishbone DMA master: FSM states, the latched command
// record and sizing of the outstanding-strobe counter.
package wb_pkg;

  localparam int WB_ADDR_BITS_DEF = 23;
  localparam int LEN_BITS_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } dma_state_t;

  // Sized by the package defaults; the master's width parameters follow them.
  typedef struct packed {
    logic                        we;
    logic [LEN_BITS_DEF-1:0]     len;
    logic [WB_ADDR_BITS_DEF-1:0] addr;
  } dma_cmd_t;

  // One extra bit so the counter can hold MAX_OUTSTANDING itself.
  function automatic int outstanding_bits(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo.sv
// Small synchronous AXI-Stream FIFO with a tuser side channel and an
// occupancy output; DEPTH must be a power of two.
module axis_fifo #(
  parameter int DATA_W = 16,
  parameter int USER_W = 1,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [DATA_W-1:0]        s_tdata,
  input  logic [USER_W-1:0]        s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [USER_W-1:0]        m_tuser,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_W+USER_W-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic                     push;
  logic                     pop;

  assign s_tready = (count != FULL);
  assign m_tvalid = (count != '0);
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;
  assign {m_tuser, m_tdata} = mem[rd_ptr];

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count alone define validity, and a reset would stop RAM inference.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_tuser, s_tdata};
  end

endmodule

// File: rtl/wb_dma_master.sv
// Pipelined Wishbone master moving a block of words between AXI-Stream and a
// Wishbone slave; reads are credit-limited to what the return buffer can hold.
module wb_dma_master
  import wb_pkg::*;
#(
  parameter int WB_ADDR_BITS    = WB_ADDR_BITS_DEF,
  parameter int DATA_BYTES      = 2,
  parameter int LEN_BITS        = LEN_BITS_DEF,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      sresetn,
  input  logic                      cmd_i_valid,
  output logic                      cmd_i_ready,
  input  logic [WB_ADDR_BITS-1:0]   cmd_i_addr,
  input  logic [LEN_BITS-1:0]       cmd_i_len,
  input  logic                      cmd_i_we,
  output logic                      done,
  output logic                      done_err,
  output logic                      busy,
  input  logic                      axis_i_tvalid,
  output logic                      axis_i_tready,
  input  logic [DATA_BYTES*8-1:0]   axis_i_tdata,
  input  logic                      axis_i_tlast,
  output logic                      axis_o_tvalid,
  input  logic                      axis_o_tready,
  output logic [DATA_BYTES*8-1:0]   axis_o_tdata,
  output logic                      axis_o_tlast,
  output logic                      m_wb_cyc,
  output logic                      m_wb_stb,
  output logic                      m_wb_we,
  output logic [WB_ADDR_BITS-1:0]   m_wb_addr,
  output logic [DATA_BYTES*8-1:0]   m_wb_dat_m2s,
  input  logic [DATA_BYTES*8-1:0]   m_wb_dat_s2m,
  input  logic                      m_wb_ack,
  input  logic                      m_wb_stall
);

  localparam int DW = DATA_BYTES * 8;
  localparam int OW = outstanding_bits(MAX_OUTSTANDING);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  dma_state_t          state, state_nxt;
  dma_cmd_t            cmd;
  logic [LEN_BITS-1:0] remaining;
  logic [LEN_BITS-1:0] ack_cnt;
  logic [OW-1:0]       outstanding, outstanding_nxt;
  logic [OW-1:0]       rd_count;
  logic [OW:0]         credit_sum;
  logic                err;
  logic                rst_done;
  logic                accept, issue, ack_v, credit_ok;
  logic                rd_buf_ready, rd_push, rd_last;

  assign m_wb_cyc     = (state == ISSUE) || (state == DRAIN);
  assign credit_sum   = {1'b0, outstanding} + {1'b0, rd_count};
  // Reads count words already sitting in the buffer: acks cannot be refused.
  assign credit_ok    = (outstanding < MAX_OUT) &&
                        (cmd.we ? axis_i_tvalid
                                : (rd_buf_ready && (credit_sum < {1'b0, MAX_OUT})));
  assign m_wb_stb     = (state == ISSUE) && credit_ok;
  assign m_wb_we      = m_wb_cyc && cmd.we;
  assign m_wb_addr    = cmd.addr;
  assign m_wb_dat_m2s = (m_wb_stb && cmd.we) ? axis_i_tdata : '0;
  assign issue        = m_wb_stb && !m_wb_stall;
  assign axis_i_tready = issue && cmd.we;
  assign ack_v        = m_wb_ack && m_wb_cyc;

  assign cmd_i_ready  = (state == IDLE) && rst_done;
  assign accept       = cmd_i_valid && cmd_i_ready;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign done_err     = done && err;

  assign rd_push      = ack_v && !cmd.we;
  assign rd_last      = (ack_cnt == cmd.len - 1'b1);

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    outstanding_nxt = outstanding;
    if (issue && !ack_v)      outstanding_nxt = outstanding + 1'b1;
    else if (!issue && ack_v) outstanding_nxt = outstanding - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (cmd_i_len == '0) ? DONE : ISSUE;
      ISSUE:   if (issue && remaining == LEN_BITS'(1))
                 state_nxt = (outstanding_nxt == '0) ? DONE : DRAIN;
      DRAIN:   if (outstanding_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state       <= IDLE;
      cmd         <= '0;
      remaining   <= '0;
      ack_cnt     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      rst_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      rst_done    <= 1'b1;
      if (accept) begin
        cmd       <= '{we: cmd_i_we, len: cmd_i_len, addr: cmd_i_addr};
        remaining <= cmd_i_len;
        ack_cnt   <= '0;
      end
      if (issue) begin
        cmd.addr  <= cmd.addr + 1'b1;
        remaining <= remaining - 1'b1;
        // tlast must appear on exactly the final beat of a write.
        if (cmd.we && (axis_i_tlast != (remaining == LEN_BITS'(1)))) err <= 1'b1;
      end
      if (rd_push) ack_cnt <= ack_cnt + 1'b1;
      if (state == DONE) err <= 1'b0;
    end
  end

  axis_fifo #(
    .DATA_W (DW),
    .USER_W (1),
    .DEPTH  (MAX_OUTSTANDING)
  ) u_rd_buf (
    .clk      (clk),
    .rst_n    (sresetn),
    .s_tvalid (rd_push),
    .s_tready (rd_buf_ready),
    .s_tdata  (m_wb_dat_s2m),
    .s_tuser  (rd_last),
    .m_tvalid (axis_o_tvalid),
    .m_tready (axis_o_tready),
    .m_tdata  (axis_o_tdata),
    .m_tuser  (axis_o_tlast),
    .count    (rd_count)
  );

endmodule
